// File: rtl/eforth1_pkg.sv
`default_nettype none
// ============================================================================
// Module : eforth1_pkg
// Brief  : Shared op codes and engine states for the eForth1 stack engine.
// Rev    : 1.0
// ============================================================================
package eforth1_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_SET  = 3'd1,
        OP_PUSH = 3'd2,
        OP_POP  = 3'd3,
        OP_SWAP = 3'd4,
        OP_PICK = 3'd5
    } stk_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_PICK   = 2'd2
    } stk_st_e;

endpackage
`default_nettype wire

// File: rtl/eforth1_stack_ram.sv
`default_nettype none
// ============================================================================
// Module : eforth1_stack_ram
// Brief  : DEPTH x DSZ single-port RAM, synchronous write, 1-cycle sync read.
// Rev    : 1.0
// ============================================================================
module eforth1_stack_ram #(
    parameter  int DEPTH = 64,
    parameter  int DSZ   = 16,
    localparam int SSZ   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           en,
    input  logic           we,
    input  logic [SSZ-1:0] addr,
    input  logic [DSZ-1:0] wdata,
    output logic [DSZ-1:0] rdata
);

    logic [DSZ-1:0] mem [DEPTH];

    // Read data holds between accesses so a PICK result stays stable.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/eforth1_stack_eng.sv
`default_nettype none
// ============================================================================
// Module : eforth1_stack_eng
// Brief  : eForth1 stack engine: TOS/NOS in registers, deeper entries in RAM.
//          Define STACK_GUARD_EN to suppress overflow/underflow ops and flag them.
// Rev    : 1.0
// ============================================================================
module eforth1_stack_eng
    import eforth1_pkg::*;
#(
    parameter  int DEPTH = 64,
    parameter  int DSZ   = 16,
    localparam int SSZ   = $clog2(DEPTH),
    localparam int CSZ   = $clog2(DEPTH + 3)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  stk_op_e        op,
    input  logic           op_vld,
    output logic           rdy,
    input  logic [DSZ-1:0] vi,
    input  logic [CSZ-1:0] pick_n,
    output logic [DSZ-1:0] t,
    output logic [DSZ-1:0] s,
    output logic [CSZ-1:0] cnt,
    output logic           empty,
    output logic           full,
    output logic [DSZ-1:0] pick_vo,
    output logic           pick_vld,
    output logic           err_ovf,
    output logic           err_unf,
    input  logic           err_clr
);

    localparam logic [CSZ-1:0] CNT_CAP = CSZ'(DEPTH + 2);
    localparam logic [CSZ-1:0] CNT_TWO = CSZ'(2);

    stk_st_e        state;
    logic [SSZ-1:0] sp;
    logic           accept;
    logic           ovf_hit;
    logic           unf_hit;
    logic           ram_en;
    logic           ram_we;
    logic [SSZ-1:0] ram_addr;
    logic [DSZ-1:0] ram_rdata;
    logic           pick_ram;
    logic [DSZ-1:0] pick_hold;

    assign accept = op_vld && (state == ST_IDLE);
    assign rdy    = (state == ST_IDLE);
    assign empty  = (cnt == '0);
    assign full   = (cnt == CNT_CAP);

`ifdef STACK_GUARD_EN
    assign ovf_hit = accept && (op == OP_PUSH) && (cnt == CNT_CAP);
    assign unf_hit = accept && (((op == OP_POP)  && (cnt == '0))     ||
                                ((op == OP_SWAP) && (cnt < CNT_TWO)) ||
                                ((op == OP_PICK) && (pick_n >= cnt)));
`else
    assign ovf_hit = 1'b0;
    assign unf_hit = 1'b0;
`endif

    // RAM slot sp is the next free entry; sp-1 sits directly under NOS.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = sp;
        if (accept) begin
            case (op)
                OP_PUSH: begin
                    if (!ovf_hit && (cnt >= CNT_TWO)) begin
                        ram_en = 1'b1;
                        ram_we = 1'b1;
                    end
                end
                OP_POP: begin
                    if (!unf_hit && (cnt > CNT_TWO)) begin
                        ram_en   = 1'b1;
                        ram_addr = sp - SSZ'(1);
                    end
                end
                OP_PICK: begin
                    if (!unf_hit && (pick_n >= CNT_TWO)) begin
                        ram_en   = 1'b1;
                        ram_addr = sp - (SSZ'(pick_n) - SSZ'(1));
                    end
                end
                default: ;
            endcase
        end
    end

    eforth1_stack_ram #(
        .DEPTH (DEPTH),
        .DSZ   (DSZ)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (s),
        .rdata (ram_rdata)
    );

    assign pick_vo = pick_vld ? (pick_ram ? ram_rdata : pick_hold) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            t         <= '0;
            s         <= '0;
            sp        <= '0;
            cnt       <= '0;
            pick_vld  <= 1'b0;
            pick_ram  <= 1'b0;
            pick_hold <= '0;
            err_ovf   <= 1'b0;
            err_unf   <= 1'b0;
        end else begin
            pick_vld <= 1'b0;

            // A same-cycle error beats the clear request.
            if (ovf_hit) begin
                err_ovf <= 1'b1;
            end else if (err_clr) begin
                err_ovf <= 1'b0;
            end
            if (unf_hit) begin
                err_unf <= 1'b1;
            end else if (err_clr) begin
                err_unf <= 1'b0;
            end

            case (state)
                ST_REFILL: begin
                    s     <= ram_rdata;
                    state <= ST_IDLE;
                end
                ST_PICK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    if (accept) begin
                        case (op)
                            OP_SET: t <= vi;
                            OP_PUSH: begin
                                if (!ovf_hit) begin
                                    if (cnt >= CNT_TWO) begin
                                        sp <= sp + SSZ'(1);
                                    end
                                    s   <= t;
                                    t   <= vi;
                                    cnt <= cnt + CSZ'(1);
                                end
                            end
                            OP_POP: begin
                                if (!unf_hit) begin
                                    t   <= s;
                                    cnt <= cnt - CSZ'(1);
                                    if (cnt > CNT_TWO) begin
                                        sp    <= sp - SSZ'(1);
                                        state <= ST_REFILL;
                                    end else begin
                                        s <= '0;
                                    end
                                end
                            end
                            OP_SWAP: begin
                                if (!unf_hit) begin
                                    t <= s;
                                    s <= t;
                                end
                            end
                            OP_PICK: begin
                                pick_vld <= 1'b1;
                                if (unf_hit) begin
                                    pick_ram  <= 1'b0;
                                    pick_hold <= '0;
                                end else begin
                                    state     <= ST_PICK;
                                    pick_ram  <= (pick_n >= CNT_TWO);
                                    pick_hold <= (pick_n == '0) ? t : s;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eforth1_stack_eng.sv
`default_nettype none
// ============================================================================
// Module : tb_eforth1_stack_eng
// Brief  : Directed vector table plus random ops against a queue-based model.
// Rev    : 1.0
// ============================================================================
module tb_eforth1_stack_eng;
    import eforth1_pkg::*;

    localparam int DEPTH = 4;
    localparam int DSZ   = 16;
    localparam int CSZ   = 3;
    localparam int CAP   = 6;
`ifdef STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    stk_op_e        op = OP_NOP;
    logic           op_vld = 1'b0;
    logic           rdy;
    logic [DSZ-1:0] vi = '0;
    logic [CSZ-1:0] pick_n = '0;
    logic [DSZ-1:0] t, s, pick_vo;
    logic [CSZ-1:0] cnt;
    logic           empty, full, pick_vld, err_ovf, err_unf;
    logic           err_clr = 1'b0;

    int total = 0;
    int bad   = 0;

    eforth1_stack_eng #(.DEPTH(DEPTH), .DSZ(DSZ)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .op_vld(op_vld), .rdy(rdy), .vi(vi),
        .pick_n(pick_n), .t(t), .s(s), .cnt(cnt), .empty(empty), .full(full),
        .pick_vo(pick_vo), .pick_vld(pick_vld), .err_ovf(err_ovf), .err_unf(err_unf),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (rdy !== 1'b1 && k < 8) begin
            @(posedge clk); #1; k++;
        end
        if (rdy !== 1'b1) chk("rdy_timeout", {31'd0, rdy}, 32'd1);
    endtask

    // Issue one op, report busy cycles and the pick result seen after acceptance.
    task automatic run_op(input stk_op_e o, input logic [DSZ-1:0] v, input logic [CSZ-1:0] n,
                          output int busy, output logic pv, output logic [DSZ-1:0] po);
        wait_idle();
        op = o; vi = v; pick_n = n; op_vld = 1'b1;
        @(posedge clk); #1;
        op_vld = 1'b0; op = OP_NOP;
        pv = pick_vld; po = pick_vo;
        busy = 0;
        while (rdy !== 1'b1 && busy < 8) begin
            @(posedge clk); #1; busy++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Reference model: TOS/NOS plus a queue of the deeper entries (front = just under NOS).
    logic [DSZ-1:0] mt, ms;
    logic [DSZ-1:0] deep[$];
    int             mcnt;
    logic           movf, munf;

    task automatic model_reset();
        mt = '0; ms = '0; deep.delete(); mcnt = 0; movf = 1'b0; munf = 1'b0;
    endtask

    task automatic model_step(input stk_op_e o, input logic [DSZ-1:0] v, input int n,
                              output int eb, output logic epv, output logic [DSZ-1:0] epo);
        logic [DSZ-1:0] tmp;
        eb = 0; epv = 1'b0; epo = '0;
        case (o)
            OP_SET: mt = v;
            OP_PUSH: begin
                if (GUARD && mcnt == CAP) movf = 1'b1;
                else begin
                    if (mcnt >= 2) deep.push_front(ms);
                    ms = mt; mt = v; mcnt++;
                end
            end
            OP_POP: begin
                if (GUARD && mcnt == 0) munf = 1'b1;
                else begin
                    mt = ms;
                    if (mcnt > 2) begin ms = deep.pop_front(); eb = 1; end
                    else ms = '0;
                    mcnt--;
                end
            end
            OP_SWAP: begin
                if (GUARD && mcnt < 2) munf = 1'b1;
                else begin tmp = mt; mt = ms; ms = tmp; end
            end
            OP_PICK: begin
                epv = 1'b1;
                if (GUARD && n >= mcnt) munf = 1'b1;
                else begin
                    eb = 1;
                    epo = (n == 0) ? mt : (n == 1) ? ms : deep[n-2];
                end
            end
            default: ;
        endcase
    endtask

    typedef struct {
        stk_op_e        o;
        logic [DSZ-1:0] v;
        logic [CSZ-1:0] n;
        logic [DSZ-1:0] et, es;
        int             ecnt, ebusy;
        logic           epv;
        logic [DSZ-1:0] epo;
    } vec_t;

    vec_t vecs[20];

    initial begin
        int             busy;
        logic           pv;
        logic [DSZ-1:0] po;

        vecs[0]  = '{OP_PUSH, 16'h1, 3'd0, 16'h1, 16'h0, 1, 0, 1'b0, 16'h0};
        vecs[1]  = '{OP_PUSH, 16'h2, 3'd0, 16'h2, 16'h1, 2, 0, 1'b0, 16'h0};
        vecs[2]  = '{OP_PUSH, 16'h3, 3'd0, 16'h3, 16'h2, 3, 0, 1'b0, 16'h0};
        vecs[3]  = '{OP_PUSH, 16'h4, 3'd0, 16'h4, 16'h3, 4, 0, 1'b0, 16'h0};
        vecs[4]  = '{OP_PUSH, 16'h5, 3'd0, 16'h5, 16'h4, 5, 0, 1'b0, 16'h0};
        vecs[5]  = '{OP_PUSH, 16'h6, 3'd0, 16'h6, 16'h5, 6, 0, 1'b0, 16'h0};
        vecs[6]  = '{OP_POP,  16'h0, 3'd0, 16'h5, 16'h4, 5, 1, 1'b0, 16'h0};
        vecs[7]  = '{OP_POP,  16'h0, 3'd0, 16'h4, 16'h3, 4, 1, 1'b0, 16'h0};
        vecs[8]  = '{OP_POP,  16'h0, 3'd0, 16'h3, 16'h2, 3, 1, 1'b0, 16'h0};
        vecs[9]  = '{OP_POP,  16'h0, 3'd0, 16'h2, 16'h1, 2, 1, 1'b0, 16'h0};
        vecs[10] = '{OP_POP,  16'h0, 3'd0, 16'h1, 16'h0, 1, 0, 1'b0, 16'h0};
        vecs[11] = '{OP_POP,  16'h0, 3'd0, 16'h0, 16'h0, 0, 0, 1'b0, 16'h0};
        vecs[12] = '{OP_PUSH, 16'hA, 3'd0, 16'hA, 16'h0, 1, 0, 1'b0, 16'h0};
        vecs[13] = '{OP_PUSH, 16'hB, 3'd0, 16'hB, 16'hA, 2, 0, 1'b0, 16'h0};
        vecs[14] = '{OP_PUSH, 16'hC, 3'd0, 16'hC, 16'hB, 3, 0, 1'b0, 16'h0};
        vecs[15] = '{OP_SWAP, 16'h0, 3'd0, 16'hB, 16'hC, 3, 0, 1'b0, 16'h0};
        vecs[16] = '{OP_PICK, 16'h0, 3'd2, 16'hB, 16'hC, 3, 1, 1'b1, 16'hA};
        vecs[17] = '{OP_PICK, 16'h0, 3'd0, 16'hB, 16'hC, 3, 1, 1'b1, 16'hB};
        vecs[18] = '{OP_PICK, 16'h0, 3'd1, 16'hB, 16'hC, 3, 1, 1'b1, 16'hC};
        vecs[19] = '{OP_SET,  16'h77, 3'd0, 16'h77, 16'hC, 3, 0, 1'b0, 16'h0};

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_t", t, 0);
        chk("reset_cnt", cnt, 0);
        chk("reset_rdy", rdy, 1);
        chk("reset_empty", empty, 1);

        // Reset landing in the middle of a refill, then in the middle of a pick.
        for (int i = 1; i <= 3; i++) run_op(OP_PUSH, 16'(i), 3'd0, busy, pv, po);
        op = OP_POP; op_vld = 1'b1;
        @(posedge clk); #1;
        op_vld = 1'b0; op = OP_NOP;
        chk("in_refill_rdy", rdy, 0);
        rst_n = 1'b0; #2;
        chk("rst_refill_t", t, 0);
        chk("rst_refill_s", s, 0);
        chk("rst_refill_cnt", cnt, 0);
        chk("rst_refill_rdy", rdy, 1);
        chk("rst_refill_empty", empty, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        run_op(OP_PUSH, 16'h9, 3'd0, busy, pv, po);
        op = OP_PICK; pick_n = 3'd0; op_vld = 1'b1;
        @(posedge clk); #1;
        op_vld = 1'b0; op = OP_NOP;
        chk("pick_pulse_pre", pick_vld, 1);
        rst_n = 1'b0; #2;
        chk("rst_pick_vld", pick_vld, 0);
        chk("rst_pick_vo", pick_vo, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            run_op(vecs[i].o, vecs[i].v, vecs[i].n, busy, pv, po);
            chk($sformatf("vec%0d_t", i), t, vecs[i].et);
            chk($sformatf("vec%0d_s", i), s, vecs[i].es);
            chk($sformatf("vec%0d_cnt", i), cnt, vecs[i].ecnt);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].ebusy);
            chk($sformatf("vec%0d_pvld", i), pv, vecs[i].epv);
            chk($sformatf("vec%0d_pvo", i), po, vecs[i].epo);
            chk($sformatf("vec%0d_full", i), full, (vecs[i].ecnt == CAP) ? 1 : 0);
        end

        // Op held valid across a refill must be taken exactly once.
        do_reset();
        for (int i = 1; i <= 4; i++) run_op(OP_PUSH, 16'(i), 3'd0, busy, pv, po);
        op = OP_POP; op_vld = 1'b1;
        @(posedge clk); #1;
        op = OP_PUSH; vi = 16'h55;
        @(posedge clk); #1;
        chk("hold_rdy_back", rdy, 1);
        @(posedge clk); #1;
        op_vld = 1'b0; op = OP_NOP;
        wait_idle();
        chk("hold_cnt", cnt, 4);
        chk("hold_t", t, 16'h55);
        chk("hold_s", s, 16'h3);

        do_reset();
        for (int i = 1; i <= 6; i++) run_op(OP_PUSH, 16'(i), 3'd0, busy, pv, po);
`ifdef STACK_GUARD_EN
        run_op(OP_PUSH, 16'h7, 3'd0, busy, pv, po);
        chk("g_ovf_cnt", cnt, 6);
        chk("g_ovf_t", t, 6);
        chk("g_ovf_flag", err_ovf, 1);
        err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
        chk("g_ovf_clr", err_ovf, 0);
        for (int i = 0; i < 6; i++) run_op(OP_POP, 16'h0, 3'd0, busy, pv, po);
        run_op(OP_POP, 16'h0, 3'd0, busy, pv, po);
        chk("g_unf_cnt", cnt, 0);
        chk("g_unf_flag", err_unf, 1);
        err_clr = 1'b1;
        run_op(OP_SWAP, 16'h0, 3'd0, busy, pv, po);
        err_clr = 1'b0;
        chk("g_set_beats_clr", err_unf, 1);
        run_op(OP_PICK, 16'h0, 3'd1, busy, pv, po);
        chk("g_bad_pick_vld", pv, 1);
        chk("g_bad_pick_vo", po, 0);
        chk("g_bad_pick_busy", busy, 0);
`else
        run_op(OP_PUSH, 16'h7, 3'd0, busy, pv, po);
        chk("ng_cnt", cnt, 7);
        chk("ng_t", t, 7);
        chk("ng_s", s, 6);
        chk("ng_ovf", err_ovf, 0);
        run_op(OP_PICK, 16'h0, 3'd2, busy, pv, po);
        chk("ng_pick2", po, 16'h5);
        run_op(OP_PICK, 16'h0, 3'd5, busy, pv, po);
        chk("ng_pick5", po, 16'h2);
        run_op(OP_PICK, 16'h0, 3'd6, busy, pv, po);
        chk("ng_pick6_overwritten", po, 16'h5);
`endif

        // Random phase against the queue model.
        do_reset();
        model_reset();
        for (int i = 0; i < 400; i++) begin
            stk_op_e        o;
            logic [DSZ-1:0] v;
            int             n, eb;
            logic           epv;
            logic [DSZ-1:0] epo;
            o = stk_op_e'($urandom_range(0, 5));
            v = 16'($urandom);
            n = 0;
            if (o == OP_PICK) n = (mcnt > 0) ? $urandom_range(0, mcnt - 1) : 0;
            if (!GUARD || $urandom_range(0, 9) != 0) begin
                if (o == OP_PUSH && mcnt == CAP) o = OP_POP;
                else if (o == OP_POP && mcnt == 0) o = OP_PUSH;
                else if (o == OP_SWAP && mcnt < 2) o = OP_PUSH;
                else if (o == OP_PICK && mcnt == 0) o = OP_PUSH;
            end else if (o == OP_PICK) begin
                n = $urandom_range(0, 7);
            end
            model_step(o, v, n, eb, epv, epo);
            run_op(o, v, 3'(n), busy, pv, po);
            chk($sformatf("rnd%0d_t", i), t, mt);
            chk($sformatf("rnd%0d_s", i), s, ms);
            chk($sformatf("rnd%0d_cnt", i), cnt, mcnt);
            chk($sformatf("rnd%0d_busy", i), busy, eb);
            chk($sformatf("rnd%0d_pvld", i), pv, epv);
            chk($sformatf("rnd%0d_pvo", i), po, epo);
            chk($sformatf("rnd%0d_empty", i), empty, (mcnt == 0) ? 1 : 0);
            chk($sformatf("rnd%0d_ovf", i), err_ovf, movf);
            chk($sformatf("rnd%0d_unf", i), err_unf, munf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
